// File: rtl/truenorth_pkg.sv
// Shared constants and types for the core SRAM access path.
package truenorth_pkg;

  localparam int CORE_SRAM_W = 410;
  localparam int CORE_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_PROG = 2'b01;
  localparam logic [1:0] ERR_RT   = 2'b10;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between the PROG and RT ports.
// tick_busy favours RT, otherwise PROG is favoured.
// starve inverts the tie-break so the usual loser wins once.
module sram_arb_pick (
  input  logic prog_req,
  input  logic rt_req,
  input  logic tick_busy,
  input  logic starve,
  output logic win_prog,
  output logic win_rt
);

  logic rt_first;

  // tie-break direction, one-hot result
  always_comb begin
    rt_first = tick_busy ^ starve;
    win_rt   = rt_req & (~prog_req | rt_first);
    win_prog = prog_req & (~rt_req | ~rt_first);
  end

endmodule

// File: rtl/core_sram_arbiter.sv
// Single-port access sequencer for the core SRAM (PROG vs RT port).
// One access in flight: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// favoured grants against a waiting loser, the loser is granted once.
module core_sram_arbiter
  import truenorth_pkg::*;
#(
  parameter int DATA_W  = CORE_SRAM_W,
  parameter int ADDR_W  = CORE_ADDR_W,
  parameter int TIMEOUT = 64
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_busy,
  input  logic              prog_req,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic              prog_gnt,
  output logic              prog_done,
  input  logic              rt_req,
  input  logic              rt_we,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] rt_wdata,
  output logic              rt_gnt,
  output logic              rt_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready,
  input  logic              err_clr,
  output logic              arb_error,
  output logic [1:0]        err_src
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(TIMEOUT);

  arb_state_t       state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             we_q;
  logic             win_prog;
  logic             win_rt;
  logic             starve;

  sram_arb_pick u_pick (
    .prog_req (prog_req),
    .rt_req   (rt_req),
    .tick_busy(tick_busy),
    .starve   (starve),
    .win_prog (win_prog),
    .win_rt   (win_rt)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt_q;
  logic [SC_W-1:0] starve_cnt_d;
  logic            loser_req;
  logic            loser_won;
  logic            arb_fire;

  assign starve = (starve_cnt_q == SC_W'(STARVE_LIMIT));

  // count favoured grants made while the loser was waiting
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    loser_req    = tick_busy ? prog_req : rt_req;
    loser_won    = tick_busy ? win_prog : win_rt;
    arb_fire     = (state_q == IDLE) & (win_prog | win_rt);
    if (!loser_req) begin
      starve_cnt_d = '0;
    end else if (arb_fire) begin
      starve_cnt_d = loser_won ? '0 : starve_cnt_q + 1'b1;
    end
  end

  // starve counter register
  always_ff @(posedge clk) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  assign starve = 1'b0;
`endif

  // access sequencer with registered grants, strobes and status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      prog_gnt   <= 1'b0;
      rt_gnt     <= 1'b0;
      prog_done  <= 1'b0;
      rt_done    <= 1'b0;
      rd_data    <= '0;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      arb_error  <= 1'b0;
      err_src    <= ERR_NONE;
    end else begin
      prog_done  <= 1'b0;
      rt_done    <= 1'b0;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      if (err_clr) begin
        arb_error <= 1'b0;
        err_src   <= ERR_NONE;
      end
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (win_prog | win_rt) begin
            state_q    <= ISSUE;
            prog_gnt   <= win_prog;
            rt_gnt     <= win_rt;
            we_q       <= win_prog ? prog_we : rt_we;
            sram_addr  <= win_prog ? prog_addr : rt_addr;
            sram_wdata <= win_prog ? prog_wdata : rt_wdata;
            sram_wr_en <= win_prog ? prog_we : rt_we;
            sram_rd_en <= win_prog ? ~prog_we : ~rt_we;
          end
        end
        ISSUE: begin
          state_q    <= WAIT;
          wait_cnt_q <= '0;
        end
        WAIT: begin
          if (sram_ready) begin
            if (!we_q) rd_data <= sram_rdata;
            state_q   <= DONE;
            prog_done <= prog_gnt;
            rt_done   <= rt_gnt;
          end else if (wait_cnt_q == TO_LAST) begin
            // a timeout overrides an err_clr in the same cycle
            arb_error  <= 1'b1;
            err_src    <= prog_gnt ? ERR_PROG : ERR_RT;
            rd_data    <= '0;
            wait_cnt_q <= TO_FULL;
            state_q    <= DONE;
            prog_done  <= prog_gnt;
            rt_done    <= rt_gnt;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          prog_gnt <= 1'b0;
          rt_gnt   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sram_arbiter.sv
// Directed self-checking bench for core_sram_arbiter with a small SRAM model.
module tb_core_sram_arbiter;

  localparam int DW = 410;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_busy = 1'b0;
  logic          prog_req = 1'b0, prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic          prog_gnt, prog_done;
  logic          rt_req = 1'b0, rt_we = 1'b0;
  logic [AW-1:0] rt_addr = '0;
  logic [DW-1:0] rt_wdata = '0;
  logic          rt_gnt, rt_done;
  logic [DW-1:0] rd_data;
  logic          sram_rd_en, sram_wr_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          sram_ready;
  logic          err_clr = 1'b0;
  logic          arb_error;
  logic [1:0]    err_src;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] D_PAT = {10'h2AB, {12{32'hDEADBEEF}}, 16'h1234};
  logic [DW-1:0] E_PAT = {10'h155, {12{32'h0BADF00D}}, 16'hA5A5};

  // SRAM model: ready asserted ready_delay cycles after the strobe cycle
  logic [DW-1:0] mem [256];
  logic          ready_en = 1'b1;
  int            ready_delay = 1;
  logic          pend = 1'b0;
  int            dly_cnt = 0;
  int            viol = 0;
  logic          rt_seen = 1'b0;

  assign sram_rdata = mem[sram_addr];
  assign sram_ready = pend && ready_en && (dly_cnt == ready_delay);

  always #5 clk = ~clk;

  core_sram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .tick_busy(tick_busy),
    .prog_req(prog_req), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_gnt(prog_gnt), .prog_done(prog_done),
    .rt_req(rt_req), .rt_we(rt_we), .rt_addr(rt_addr), .rt_wdata(rt_wdata),
    .rt_gnt(rt_gnt), .rt_done(rt_done), .rd_data(rd_data),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .err_clr(err_clr), .arb_error(arb_error), .err_src(err_src)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      dly_cnt <= 0;
    end else begin
      if (sram_wr_en) mem[sram_addr] <= sram_wdata;
      if (sram_rd_en || sram_wr_en) begin
        pend    <= 1'b1;
        dly_cnt <= 1;
      end else if (sram_ready) begin
        pend <= 1'b0;
      end else if (pend) begin
        dly_cnt <= dly_cnt + 1;
      end
      if (prog_gnt && rt_gnt) viol <= viol + 1;
      if (sram_rd_en && sram_wr_en) viol <= viol + 1;
      if (rt_gnt) rt_seen <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit want_rt, output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      cyc++;
      if (want_rt ? rt_done : prog_done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({prog_gnt, rt_gnt, prog_done, rt_done, sram_rd_en, sram_wr_en, arb_error} !== 7'b0 ||
        err_src !== 2'b00 || rd_data !== '0 || sram_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b done=%b%b strb=%b%b err=%b src=%b", prog_gnt, rt_gnt,
               prog_done, rt_done, sram_rd_en, sram_wr_en, arb_error, err_src);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_prog_write_read();
    int cyc; bit to;
    rt_seen = 1'b0;
    ready_en = 1'b1; ready_delay = 2; tick_busy = 1'b0;
    prog_req = 1'b1; prog_we = 1'b1; prog_addr = 8'h10; prog_wdata = D_PAT;
    tick();
    checks++;
    if (sram_wr_en !== 1'b1 || sram_rd_en !== 1'b0 || prog_gnt !== 1'b1 || sram_addr !== 8'h10 ||
        sram_wdata !== D_PAT) begin
      errors++;
      $display("FAIL wr_issue: wr=%b rd=%b gnt=%b addr=%h expected wr=1 rd=0 gnt=1 addr=10",
               sram_wr_en, sram_rd_en, prog_gnt, sram_addr);
    end
    wait_done(1'b0, cyc, to);
    prog_req = 1'b0;
    checks++;
    if (to || cyc != 3) begin
      errors++;
      $display("FAIL wr_latency: done %0d cycles after strobe (timeout=%0b) expected 3", cyc, to);
    end
    tick();
    ready_delay = 1;
    prog_req = 1'b1; prog_we = 1'b0; prog_addr = 8'h10; prog_wdata = '0;
    tick();
    checks++;
    if (sram_rd_en !== 1'b1 || sram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rd_issue: rd=%b wr=%b expected rd=1 wr=0", sram_rd_en, sram_wr_en);
    end
    wait_done(1'b0, cyc, to);
    prog_req = 1'b0;
    checks++;
    if (to || rd_data !== D_PAT) begin
      errors++;
      $display("FAIL rd_data: got %h expected %h", rd_data, D_PAT);
    end
    tick();
    checks++;
    if (rt_seen !== 1'b0 || prog_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rt_idle: rt_seen=%b prog_gnt=%b expected 0 0", rt_seen, prog_gnt);
    end
  endtask

  task automatic test_priority(input bit tb_val);
    int cyc; bit to;
    ready_en = 1'b1; ready_delay = 1; tick_busy = tb_val;
    prog_req = 1'b1; prog_we = 1'b1; prog_addr = 8'h21; prog_wdata = E_PAT;
    rt_req   = 1'b1; rt_we   = 1'b1; rt_addr   = 8'h20; rt_wdata   = D_PAT;
    tick();
    checks++;
    if (rt_gnt !== tb_val || prog_gnt !== !tb_val || sram_addr !== (tb_val ? 8'h20 : 8'h21)) begin
      errors++;
      $display("FAIL prio_first_tb%0b: rt_gnt=%b prog_gnt=%b addr=%h", tb_val, rt_gnt, prog_gnt,
               sram_addr);
    end
    wait_done(tb_val, cyc, to);
    checks++;
    if (to || cyc != 2) begin
      errors++;
      $display("FAIL prio_latency_tb%0b: got %0d expected 2", tb_val, cyc);
    end
    if (tb_val) rt_req = 1'b0; else prog_req = 1'b0;
    tick(); tick();
    checks++;
    if (rt_gnt !== !tb_val || prog_gnt !== tb_val || sram_addr !== (tb_val ? 8'h21 : 8'h20)) begin
      errors++;
      $display("FAIL prio_second_tb%0b: rt_gnt=%b prog_gnt=%b addr=%h", tb_val, rt_gnt, prog_gnt,
               sram_addr);
    end
    wait_done(!tb_val, cyc, to);
    prog_req = 1'b0; rt_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int cyc; bit to;
    ready_en = 1'b0;
    rt_req = 1'b1; rt_we = 1'b0; rt_addr = 8'h10;
    tick();
    wait_done(1'b1, cyc, to);
    rt_req = 1'b0;
    checks++;
    if (to || cyc != 65 || arb_error !== 1'b1 || err_src !== 2'b10 || rd_data !== '0) begin
      errors++;
      $display("FAIL timeout: cyc=%0d err=%b src=%b rd0=%b expected cyc=65 err=1 src=10 rd0=1", cyc,
               arb_error, err_src, (rd_data == '0));
    end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (arb_error !== 1'b0 || err_src !== 2'b00) begin
      errors++;
      $display("FAIL err_clr: err=%b src=%b expected 0 00", arb_error, err_src);
    end
    ready_en = 1'b1;
  endtask

  task automatic test_exact_timeout();
    int cyc; bit to;
    ready_en = 1'b1; ready_delay = 64;
    prog_req = 1'b1; prog_we = 1'b0; prog_addr = 8'h10;
    tick();
    wait_done(1'b0, cyc, to);
    prog_req = 1'b0;
    checks++;
    if (to || cyc != 65 || arb_error !== 1'b0 || rd_data !== D_PAT) begin
      errors++;
      $display("FAIL ready_at_timeout: cyc=%0d err=%b data_ok=%b expected 65 0 1", cyc, arb_error,
               (rd_data == D_PAT));
    end
    ready_delay = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; int seen;
    ready_en = 1'b0;
    prog_req = 1'b1; prog_we = 1'b1; prog_addr = 8'h33; prog_wdata = E_PAT;
    tick(); tick(); tick();
    rst_n = 1'b0; prog_req = 1'b0;
    tick();
    checks++;
    if ({prog_gnt, rt_gnt, prog_done, rt_done, sram_rd_en, sram_wr_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b%b done=%b%b strb=%b%b expected all 0", prog_gnt, rt_gnt,
               prog_done, rt_done, sram_rd_en, sram_wr_en);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (prog_done || prog_gnt) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d cycles with done/gnt expected 0", seen);
    end
    ready_en = 1'b1; ready_delay = 1;
    prog_req = 1'b1;
    tick();
    checks++;
    if (sram_wr_en !== 1'b1 || sram_addr !== 8'h33) begin
      errors++;
      $display("FAIL reset_fresh_issue: wr=%b addr=%h expected 1 33", sram_wr_en, sram_addr);
    end
    wait_done(1'b0, cyc, to);
    prog_req = 1'b0;
    checks++;
    if (to || cyc != 2) begin
      errors++;
      $display("FAIL reset_fresh_done: got %0d expected 2", cyc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    ready_delay = 1; tick_busy = 1'b0;
    prog_req = 1'b1; prog_we = 1'b0; prog_addr = 8'h21;
    tick();
    wait_done(1'b0, cyc, to);
    tick();
    checks++;
    if (prog_gnt !== 1'b0 || sram_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: gnt=%b rd=%b expected 0 0", prog_gnt, sram_rd_en);
    end
    tick();
    checks++;
    if (prog_gnt !== 1'b1 || sram_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL b2b_regrant: gnt=%b rd=%b expected 1 1", prog_gnt, sram_rd_en);
    end
    wait_done(1'b0, cyc, to);
    prog_req = 1'b0;
    checks++;
    if (to || rd_data !== E_PAT) begin
      errors++;
      $display("FAIL b2b_data: got %h expected %h", rd_data, E_PAT);
    end
    tick();
  endtask

  task automatic test_starvation();
    int cyc; bit to; bit got; bit is_prog; int prog_cnt; int n_acc; int bad;
`ifdef ARB_STARVE_GUARD_EN
    n_acc = 9;
`else
    n_acc = 100;
`endif
    prog_cnt = 0; bad = 0;
    ready_delay = 1; tick_busy = 1'b1;
    prog_req = 1'b1; prog_we = 1'b1; prog_addr = 8'h40;
    rt_req = 1'b1; rt_we = 1'b1; rt_addr = 8'h41;
    for (int n = 0; n < n_acc; n++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        tick();
        if (prog_gnt || rt_gnt) got = 1'b1;
      end
      is_prog = prog_gnt;
      if (!got) bad++;
      if (is_prog) prog_cnt++;
`ifdef ARB_STARVE_GUARD_EN
      if (is_prog != (n == 8)) bad++;
`endif
      wait_done(!is_prog, cyc, to);
      if (to) bad++;
    end
    prog_req = 1'b0; rt_req = 1'b0;
    tick(); tick();
    checks++;
`ifdef ARB_STARVE_GUARD_EN
    if (bad != 0 || prog_cnt != 1) begin
      errors++;
      $display("FAIL starve_guard: prog grants %0d order errors %0d expected 1 and 0", prog_cnt, bad);
    end
`else
    if (bad != 0 || prog_cnt != 0) begin
      errors++;
      $display("FAIL strict_prio: prog grants %0d errors %0d expected 0 and 0", prog_cnt, bad);
    end
`endif
  endtask

  task automatic test_invariants();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL exclusivity: got %0d overlap cycles expected 0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_prog_write_read();
    test_priority(1'b1);
    test_priority(1'b0);
    test_timeout();
    test_exact_timeout();
    test_reset_mid();
    test_back_to_back();
    test_starvation();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
